// File: rtl/fsm_seq_ctrl_if.sv
// Signal bundle between fsm_seq_ctrl and its host/bench plus the three FSMs under comparison.
interface fsm_seq_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             wr_en;
  logic [1:0]       wr_sym;
  logic             wr_full;
  logic             start;
  logic             busy;
  logic             done;
  logic             fsm_rst_n;
  logic [1:0]       fsm_a;
  logic [2:0]       s_case;
  logic [2:0]       s_mem;
  logic [2:0]       s_gate;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       last_out;
  logic [PTR_W-1:0] fail_idx;

  modport master (
    output wr_en, wr_sym, start, s_case, s_mem, s_gate,
    input  wr_full, busy, done, fsm_rst_n, fsm_a, mismatch, err_cnt, last_out, fail_idx
  );

  modport slave (
    input  wr_en, wr_sym, start, s_case, s_mem, s_gate,
    output wr_full, busy, done, fsm_rst_n, fsm_a, mismatch, err_cnt, last_out, fail_idx
  );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Buffers a symbol sequence, replays it into three FSM implementations and counts output disagreements.
// Optional macro FSM_SEQ_STOP_ON_ERR_EN: stop at the first failing check and record its index in fail_idx.
module fsm_seq_ctrl #(
  parameter int DEPTH    = 16,
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  fsm_seq_ctrl_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CW     = PTR_W + 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]     CNT1      = CW'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_DRIVE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [1:0]        sym_buf [DEPTH];
  logic [CW-1:0]     count_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [HOLD_W-1:0] hold_r;
  logic              wr_full_r;
  logic              busy_r;
  logic              done_r;
  logic              fsm_rst_n_r;
  logic [1:0]        fsm_a_r;
  logic              mismatch_r;
  logic [CNT_W-1:0]  err_cnt_r;
  logic [2:0]        last_out_r;

  logic              wr_ok_s;
  logic              diff_s;
  logic              last_s;
  logic              end_run_s;
  logic [CNT_W-1:0]  err_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;

  // Write qualification and per-check decode.
  always_comb begin
    wr_ok_s      = (state_r == ST_IDLE) && bus.wr_en && !bus.start && (count_r != DEPTH_C);
    diff_s       = (bus.s_case != bus.s_mem) || (bus.s_case != bus.s_gate);
    last_s       = ({1'b0, rd_ptr_r} == (count_r - CNT1));
    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end_run_s    = last_s;
    if (diff_s) begin
`ifdef FSM_SEQ_STOP_ON_ERR_EN
      err_nxt_s = CNT_ONE;
      end_run_s = 1'b1;
`else
      if (err_cnt_r != CNT_MAX) begin
        err_nxt_s = err_cnt_r + CNT_ONE;
      end else begin
        err_nxt_s = err_cnt_r;
      end
`endif
    end else begin
      err_nxt_s = err_cnt_r;
    end
  end

  // Symbol storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      sym_buf[wr_ptr_r] <= bus.wr_sym;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      hold_r      <= '0;
      wr_full_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fsm_rst_n_r <= 1'b1;
      fsm_a_r     <= 2'd0;
      mismatch_r  <= 1'b0;
      err_cnt_r   <= '0;
      last_out_r  <= 3'd0;
    end else begin
      done_r     <= 1'b0;
      mismatch_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            err_cnt_r <= '0;
            rd_ptr_r  <= '0;
            hold_r    <= '0;
            if (count_r == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_RST;
              busy_r      <= 1'b1;
              fsm_rst_n_r <= 1'b0;
              fsm_a_r     <= 2'd0;
            end
          end else if (wr_ok_s) begin
            wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            count_r   <= count_r + CNT1;
            wr_full_r <= ((count_r + CNT1) == DEPTH_C);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RST: begin
          fsm_rst_n_r <= 1'b1;
          fsm_a_r     <= sym_buf[rd_ptr_r];
          hold_r      <= '0;
          state_r     <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (hold_r == HOLD_LAST) begin
            hold_r  <= '0;
            state_r <= ST_CHECK;
          end else begin
            hold_r <= hold_r + HOLD_ONE;
          end
        end
        ST_CHECK: begin
          last_out_r <= bus.s_case;
          mismatch_r <= diff_s;
          err_cnt_r  <= err_nxt_s;
          if (end_run_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            fsm_a_r <= 2'd0;
          end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            fsm_a_r  <= sym_buf[rd_ptr_nxt_s];
            state_r  <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          count_r   <= '0;
          wr_ptr_r  <= '0;
          rd_ptr_r  <= '0;
          wr_full_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          fsm_rst_n_r <= 1'b1;
          fsm_a_r     <= 2'd0;
        end
      endcase
    end
  end

`ifdef FSM_SEQ_STOP_ON_ERR_EN
  logic [PTR_W-1:0] fail_idx_r;

  // Index of the check that ended the run early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_idx_r <= '0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      fail_idx_r <= '0;
    end else if ((state_r == ST_CHECK) && diff_s) begin
      fail_idx_r <= rd_ptr_r;
    end else begin
      fail_idx_r <= fail_idx_r;
    end
  end

  assign bus.fail_idx = fail_idx_r;
`else
  assign bus.fail_idx = '0;
`endif

  assign bus.wr_full   = wr_full_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.fsm_rst_n = fsm_rst_n_r;
  assign bus.fsm_a     = fsm_a_r;
  assign bus.mismatch  = mismatch_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.last_out  = last_out_r;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl: a DEPTH=16/HOLD_CYC=4/CNT_W=8 instance plus a CNT_W=2 instance for saturation.
module tb_fsm_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] syms [16];

  always #5 clk = ~clk;

  fsm_seq_ctrl_if #(.DEPTH(16), .CNT_W(8)) bus ();
  fsm_seq_ctrl_if #(.DEPTH(8),  .CNT_W(2)) bus2 ();

  fsm_seq_ctrl #(.DEPTH(16), .HOLD_CYC(4), .CNT_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  fsm_seq_ctrl #(.DEPTH(8),  .HOLD_CYC(1), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s at %0t: got %0h, want %0h", tag, what, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] sym);
    bus.wr_en  = 1'b1;
    bus.wr_sym = sym;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic push2(input logic [1:0] sym);
    bus2.wr_en  = 1'b1;
    bus2.wr_sym = sym;
    tick();
    bus2.wr_en  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, "busy",      32'(bus.busy),      32'd0);
    chk(tag, "done",      32'(bus.done),      32'd0);
    chk(tag, "mismatch",  32'(bus.mismatch),  32'd0);
    chk(tag, "wr_full",   32'(bus.wr_full),   32'd0);
    chk(tag, "fsm_rst_n", 32'(bus.fsm_rst_n), 32'd1);
    chk(tag, "fsm_a",     32'(bus.fsm_a),     32'd0);
    chk(tag, "err_cnt",   32'(bus.err_cnt),   32'd0);
    chk(tag, "last_out",  32'(bus.last_out),  32'd0);
    chk(tag, "fail_idx",  32'(bus.fail_idx),  32'd0);
    chk(tag, "busy2",     32'(bus2.busy),     32'd0);
    chk(tag, "err_cnt2",  32'(bus2.err_cnt),  32'd0);
  endtask

  // Start a run on the main instance and check every cycle against the cycle-timing model:
  // start in cycle 0, FSM reset in cycle 1, symbol k on fsm_a over cycles 2+5k..6+5k, done at exp_done.
  // s_case/s_gate follow the cycle number; s_mem is forced to 7 while symbol bad_sym is held.
  task automatic run_main(input int n, input int bad_sym, input int exp_done, input int exp_err,
                          input bit poke, input bit full, input string tag);
    int         k;
    logic [1:0] ea;
    bit         ebusy;
    bit         emm;
    bus.s_case = 3'd0;
    bus.s_mem  = 3'd0;
    bus.s_gate = 3'd0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 1; c <= exp_done; c++) begin
      bus.s_case = 3'(c);
      bus.s_gate = 3'(c);
      if (bad_sym >= 0 && c >= 2 + 5 * bad_sym && c <= 6 + 5 * bad_sym) bus.s_mem = 3'd7;
      else bus.s_mem = 3'(c);
      if (poke && c == 5) begin
        bus.wr_en  = 1'b1;
        bus.wr_sym = 2'd3;
        bus.start  = 1'b1;
      end else begin
        bus.wr_en  = 1'b0;
        bus.start  = 1'b0;
      end
      k     = (c >= 2) ? (c - 2) / 5 : 0;
      ea    = (c >= 2 && c < exp_done && k < n) ? syms[k] : 2'd0;
      ebusy = (c < exp_done);
      emm   = (bad_sym >= 0 && c == 7 + 5 * bad_sym);
      chk(tag, "fsm_a",     32'(bus.fsm_a),     32'(ea));
      chk(tag, "fsm_rst_n", 32'(bus.fsm_rst_n), (c == 1) ? 32'd0 : 32'd1);
      chk(tag, "busy",      32'(bus.busy),      32'(ebusy));
      chk(tag, "done",      32'(bus.done),      (c == exp_done) ? 32'd1 : 32'd0);
      chk(tag, "mismatch",  32'(bus.mismatch),  32'(emm));
      chk(tag, "wr_full",   32'(bus.wr_full),   32'(full));
      if (c < exp_done) tick();
    end
    chk(tag, "err_cnt",  32'(bus.err_cnt),  32'(exp_err));
    chk(tag, "last_out", 32'(bus.last_out), 32'((exp_done - 1) % 8));
    tick();
    chk(tag, "done_end",    32'(bus.done),    32'd0);
    chk(tag, "busy_end",    32'(bus.busy),    32'd0);
    chk(tag, "wr_full_end", 32'(bus.wr_full), 32'd0);
    chk(tag, "err_hold",    32'(bus.err_cnt), 32'(exp_err));
    bus.s_case = 3'd0;
    bus.s_mem  = 3'd0;
    bus.s_gate = 3'd0;
  endtask

  initial begin
    int done_cyc;
    int pulses;
    int mm_done;

    // Reset held with random inputs on both instances.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'($urandom);
      bus.wr_sym  = 2'($urandom);
      bus.start   = 1'($urandom);
      bus.s_case  = 3'($urandom);
      bus.s_mem   = 3'($urandom);
      bus.s_gate  = 3'($urandom);
      bus2.wr_en  = 1'($urandom);
      bus2.wr_sym = 2'($urandom);
      bus2.start  = 1'($urandom);
      bus2.s_case = 3'($urandom);
      bus2.s_mem  = 3'($urandom);
      bus2.s_gate = 3'($urandom);
      tick();
      chk_reset("reset");
    end
    bus.wr_en  = 1'b0; bus.wr_sym  = 2'd0; bus.start  = 1'b0;
    bus.s_case = 3'd0; bus.s_mem   = 3'd0; bus.s_gate = 3'd0;
    bus2.wr_en  = 1'b0; bus2.wr_sym = 2'd0; bus2.start  = 1'b0;
    bus2.s_case = 3'd0; bus2.s_mem  = 3'd0; bus2.s_gate = 3'd0;
    tick();
    reset = 1'b1;
    tick();
    chk_reset("post_reset");

    // Normal run 1,1,0,2 with wr_en/start poked mid-run; done at cycle 22.
    syms[0] = 2'd1; syms[1] = 2'd1; syms[2] = 2'd0; syms[3] = 2'd2;
    for (int i = 0; i < 4; i++) push(syms[i]);
    run_main(4, -1, 22, 0, 1'b1, 1'b0, "normal");

    // Third symbol disagrees on s_mem.
`ifdef FSM_SEQ_STOP_ON_ERR_EN
    mm_done = 17;
`else
    mm_done = 22;
`endif
    for (int i = 0; i < 4; i++) push(syms[i]);
    run_main(4, 2, mm_done, 1, 1'b0, 1'b0, "mismatch");
`ifdef FSM_SEQ_STOP_ON_ERR_EN
    chk("mismatch", "fail_idx", 32'(bus.fail_idx), 32'd2);
`else
    chk("mismatch", "fail_idx", 32'(bus.fail_idx), 32'd0);
`endif

    // Empty buffer: done one cycle after start, err_cnt cleared.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("empty", "done",      32'(bus.done),      32'd1);
    chk("empty", "busy",      32'(bus.busy),      32'd0);
    chk("empty", "err_cnt",   32'(bus.err_cnt),   32'd0);
    chk("empty", "fsm_rst_n", 32'(bus.fsm_rst_n), 32'd1);
    tick();
    chk("empty", "done_end",  32'(bus.done),      32'd0);

    // Seventeen pushes: full after the 16th, 17th dropped, last check is symbol 15.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) syms[i] = 2'(i);
      push(2'(i));
      chk("fill", "wr_full", 32'(bus.wr_full), (i >= 15) ? 32'd1 : 32'd0);
    end
    run_main(16, 15, 82, 1, 1'b0, 1'b1, "full");

    // Saturation on the CNT_W=2, HOLD_CYC=1 instance: five failing checks.
    for (int i = 0; i < 5; i++) push2(2'(i));
    bus2.s_mem = 3'd7;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    done_cyc = -1;
    pulses   = 0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      if (bus2.mismatch === 1'b1) pulses++;
      if (bus2.done === 1'b1) done_cyc = c;
      else tick();
    end
`ifdef FSM_SEQ_STOP_ON_ERR_EN
    chk("sat", "done_cycle", 32'(done_cyc),      32'd4);
    chk("sat", "pulses",     32'(pulses),        32'd1);
    chk("sat", "err_cnt",    32'(bus2.err_cnt),  32'd1);
`else
    chk("sat", "done_cycle", 32'(done_cyc),      32'd12);
    chk("sat", "pulses",     32'(pulses),        32'd5);
    chk("sat", "err_cnt",    32'(bus2.err_cnt),  32'd3);
`endif
    bus2.s_mem = 3'd0;
    tick();

    // Abort at cycle 10 of a run, then a fresh load and run.
    for (int i = 0; i < 4; i++) push(syms[i]);
    bus.s_case = 3'd5; bus.s_mem = 3'd5; bus.s_gate = 3'd5;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (9) tick();
    chk("abort", "busy_pre",     32'(bus.busy),     32'd1);
    chk("abort", "fsm_a_pre",    32'(bus.fsm_a),    32'(syms[1]));
    chk("abort", "last_out_pre", 32'(bus.last_out), 32'd5);
    reset = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    reset = 1'b1;
    tick();
    syms[0] = 2'd3; syms[1] = 2'd2;
    push(syms[0]);
    push(syms[1]);
    run_main(2, -1, 12, 0, 1'b0, 1'b0, "after_abort");

`ifdef FSM_SEQ_STOP_ON_ERR_EN
    // Failure on symbol 1 ends the run at the following cycle.
    syms[0] = 2'd2; syms[1] = 2'd3; syms[2] = 2'd1;
    for (int i = 0; i < 3; i++) push(syms[i]);
    run_main(3, 1, 12, 1, 1'b0, 1'b0, "stop");
    chk("stop", "fail_idx", 32'(bus.fail_idx), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
